// File: rtl/yarvi_scoreboard_if.sv
// Issue/writeback handshake between decode and the register-hazard scoreboard.
// Combinational hazard/ready outputs; issue stalls by holding insn_ready low.
interface yarvi_scoreboard_if #(
    parameter int NREGS = 32
);
    logic             insn_valid;
    logic [31:0]      insn;
    logic             insn_ready;
    logic             hazard_raw;
    logic             hazard_waw;
    logic             illegal;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             flush;
    logic [NREGS-1:0] busy;

    modport master (
        output insn_valid, insn, wb_valid, wb_rd, flush,
        input  insn_ready, hazard_raw, hazard_waw, illegal, busy
    );

    modport slave (
        input  insn_valid, insn, wb_valid, wb_rd, flush,
        output insn_ready, hazard_raw, hazard_waw, illegal, busy
    );
endinterface

// File: rtl/yarvi_scoreboard.sv
// Register-hazard scoreboard: combinational RAW/WAW/illegal check, state updates at the edge.
// A destination stays busy LAT cycles after issue (loads until writeback); stalls drop insn_ready.
module yarvi_scoreboard #(
    parameter int NREGS   = 32,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3,
    parameter int CW      = 3
) (
    input logic              clock,
    input logic              reset_n,
    yarvi_scoreboard_if.slave sb
);
    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1b;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3b;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    localparam logic [5:0]    NREGS_W = 6'(NREGS);
    localparam logic [CW-1:0] ALU_CNT = CW'(ALU_LAT);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic       dec_rs1, dec_rs2, dec_rd;
    logic       use_rs1, use_rs2, use_rd;
    logic       is_load, is_mul;
    logic       illegal_w, raw_w, waw_w, issue;

    logic [NREGS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NREGS-1:0]         ld_q, ld_d;
    logic [NREGS-1:0]         busy_w;
    logic [31:0]              busy_ext;

    assign opc    = sb.insn[6:0];
    assign rd     = sb.insn[11:7];
    assign funct3 = sb.insn[14:12];
    assign rs1    = sb.insn[19:15];
    assign rs2    = sb.insn[24:20];
    assign funct7 = sb.insn[31:25];

    always_comb begin
        dec_rs1 = 1'b0;
        dec_rs2 = 1'b0;
        dec_rd  = 1'b0;
        case (opc)
            OPC_BRANCH, OPC_STORE: begin
                dec_rs1 = 1'b1;
                dec_rs2 = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                dec_rs1 = 1'b1;
                dec_rs2 = 1'b1;
                dec_rd  = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_LOAD: begin
                dec_rs1 = 1'b1;
                dec_rd  = 1'b1;
            end
            OPC_SYSTEM: begin
                // funct3[2] selects the immediate CSR forms whose rs1 field is zimm
                dec_rs1 = (funct3[1:0] != 2'b00) && !funct3[2];
                dec_rd  = (funct3[1:0] != 2'b00);
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: dec_rd = 1'b1;
            default: ;
        endcase
    end

    assign use_rs1 = dec_rs1 && (rs1 != 5'd0);
    assign use_rs2 = dec_rs2 && (rs2 != 5'd0);
    assign use_rd  = dec_rd  && (rd  != 5'd0);
    assign is_load = (opc == OPC_LOAD);
    assign is_mul  = ((opc == OPC_OP) || (opc == OPC_OP_32)) && (funct7 == 7'h01);

    assign illegal_w = (use_rs1 && ({1'b0, rs1} >= NREGS_W)) ||
                       (use_rs2 && ({1'b0, rs2} >= NREGS_W)) ||
                       (use_rd  && ({1'b0, rd}  >= NREGS_W));

    always_comb begin
        busy_w = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_w[r] = (cnt_q[r] != '0) || ld_q[r];
        end
        // out-of-range fields read as not busy so indexing stays in bounds
        busy_ext = '0;
        busy_ext[NREGS-1:0] = busy_w;
    end

    assign raw_w = sb.insn_valid && ((use_rs1 && busy_ext[rs1]) || (use_rs2 && busy_ext[rs2]));
    assign waw_w = sb.insn_valid && use_rd && busy_ext[rd];
    assign issue = sb.insn_valid && !raw_w && !waw_w && !illegal_w && !sb.flush;

    always_comb begin
        cnt_d = cnt_q;
        ld_d  = ld_q;
        for (int r = 1; r < NREGS; r++) begin
            if (sb.flush) begin
                cnt_d[r] = '0;
            end else if (issue && use_rd && !is_load && (rd == 5'(r))) begin
                cnt_d[r] = is_mul ? MUL_CNT : ALU_CNT;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - ONE_CNT;
            end
            if (sb.wb_valid && (sb.wb_rd == 5'(r))) begin
                ld_d[r] = 1'b0;
            end
            if (issue && use_rd && is_load && (rd == 5'(r))) begin
                ld_d[r] = 1'b1;
            end
        end
        cnt_d[0] = '0;
        ld_d[0]  = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ld_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

    assign sb.hazard_raw = raw_w;
    assign sb.hazard_waw = waw_w;
    assign sb.illegal    = illegal_w;
    assign sb.insn_ready = (!raw_w && !waw_w) || illegal_w;
    assign sb.busy       = busy_w;

endmodule

// File: tb/tb_yarvi_scoreboard.sv
// Directed bench for yarvi_scoreboard: a 32-register and a 16-register instance.
module tb_yarvi_scoreboard;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    localparam logic [31:0] ADD5    = 32'h002082B3; // add x5,x1,x2
    localparam logic [31:0] ADD6_5  = 32'h00028333; // add x6,x5,x0
    localparam logic [31:0] MUL7    = 32'h024183B3; // mul x7,x3,x4
    localparam logic [31:0] SUB8    = 32'h40738433; // sub x8,x7,x7
    localparam logic [31:0] LW9     = 32'h00012483; // lw x9,0(x2)
    localparam logic [31:0] ADDI9   = 32'h00100493; // addi x9,x0,1
    localparam logic [31:0] ADD11   = 32'h002085B3; // add x11,x1,x2
    localparam logic [31:0] ADD17   = 32'h002088B3; // add x17,x1,x2
    localparam logic [31:0] ADD1_20 = 32'h002A00B3; // add x1,x20,x2
    localparam logic [31:0] CSRRWI3 = 32'h3008D1F3; // csrrwi x3,mstatus,17
    localparam logic [31:0] ADDI0   = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] BEQ0    = 32'h00000063; // beq x0,x0,0

    yarvi_scoreboard_if #(.NREGS(32)) ifa ();
    yarvi_scoreboard_if #(.NREGS(16)) ifb ();

    yarvi_scoreboard #(.NREGS(32)) dut_a (.clock(clock), .reset_n(reset_n), .sb(ifa));
    yarvi_scoreboard #(.NREGS(16)) dut_b (.clock(clock), .reset_n(reset_n), .sb(ifb));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset_n = 1'b0;
        ifa.insn_valid = 1'b0; ifa.insn = '0; ifa.wb_valid = 1'b0; ifa.wb_rd = '0; ifa.flush = 1'b0;
        ifb.insn_valid = 1'b0; ifb.insn = '0; ifb.wb_valid = 1'b0; ifb.wb_rd = '0; ifb.flush = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        ifa.insn_valid = 1'b1; ifa.insn = MUL7;
        @(negedge clock);
        ifa.insn_valid = 1'b0;
        #1;
        checks++; if (ifa.busy !== 32'h0000_0080) begin errors++; $display("FAIL reset_pre_busy got %h exp %h", ifa.busy, 32'h80); end
        reset_n = 1'b0;
        ifb.insn = ADD17;
        #1;
        checks++; if (ifa.busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", ifa.busy, 32'h0); end
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ifa.insn_ready); end
        checks++; if (ifa.hazard_raw !== 1'b0) begin errors++; $display("FAIL reset_raw got %b exp 0", ifa.hazard_raw); end
        checks++; if (ifa.hazard_waw !== 1'b0) begin errors++; $display("FAIL reset_waw got %b exp 0", ifa.hazard_waw); end
        checks++; if (ifa.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal_a got %b exp 0", ifa.illegal); end
        checks++; if (ifb.illegal !== 1'b1) begin errors++; $display("FAIL reset_illegal_b got %b exp 1", ifb.illegal); end
        checks++; if (ifb.busy !== 16'h0) begin errors++; $display("FAIL reset_busy_b got %h exp 0", ifb.busy); end
        @(negedge clock);
        reset_n = 1'b1;
        ifb.insn = '0;
    endtask

    task automatic test_alu_raw();
        @(negedge clock);
        ifa.insn_valid = 1'b1; ifa.insn = ADD5;
        #1;
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL alu_first_ready got %b exp 1", ifa.insn_ready); end
        @(negedge clock);
        ifa.insn = ADD6_5;
        #1;
        checks++; if (ifa.hazard_raw !== 1'b1) begin errors++; $display("FAIL alu_raw_stall got %b exp 1", ifa.hazard_raw); end
        checks++; if (ifa.insn_ready !== 1'b0) begin errors++; $display("FAIL alu_ready_stall got %b exp 0", ifa.insn_ready); end
        checks++; if (ifa.busy !== 32'h0000_0020) begin errors++; $display("FAIL alu_busy5 got %h exp %h", ifa.busy, 32'h20); end
        @(negedge clock);
        #1;
        checks++; if (ifa.hazard_raw !== 1'b0) begin errors++; $display("FAIL alu_raw_release got %b exp 0", ifa.hazard_raw); end
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_release got %b exp 1", ifa.insn_ready); end
        @(negedge clock);
        ifa.insn_valid = 1'b0;
        #1;
        checks++; if (ifa.busy !== 32'h0000_0040) begin errors++; $display("FAIL alu_busy6 got %h exp %h", ifa.busy, 32'h40); end
        @(negedge clock);
        #1;
        checks++; if (ifa.busy !== 32'h0) begin errors++; $display("FAIL alu_drain got %h exp 0", ifa.busy); end
    endtask

    task automatic test_mul_latency();
        @(negedge clock);
        ifa.insn_valid = 1'b1; ifa.insn = MUL7;
        #1;
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL mul_issue_ready got %b exp 1", ifa.insn_ready); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            ifa.insn = SUB8;
            #1;
            checks++; if (ifa.hazard_raw !== (k <= 3)) begin errors++; $display("FAIL mul_raw_c%0d got %b exp %b", k, ifa.hazard_raw, (k <= 3)); end
            checks++; if (ifa.busy[7] !== (k <= 3)) begin errors++; $display("FAIL mul_busy7_c%0d got %b exp %b", k, ifa.busy[7], (k <= 3)); end
            checks++; if (ifa.insn_ready !== (k == 4)) begin errors++; $display("FAIL mul_ready_c%0d got %b exp %b", k, ifa.insn_ready, (k == 4)); end
        end
        @(negedge clock);
        ifa.insn_valid = 1'b0;
        #1;
        checks++; if (ifa.busy !== 32'h0000_0100) begin errors++; $display("FAIL mul_sub_issued got %h exp %h", ifa.busy, 32'h100); end
        @(negedge clock);
    endtask

    task automatic test_load_wb();
        @(negedge clock);
        ifa.insn_valid = 1'b1; ifa.insn = LW9;
        #1;
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL ld_issue_ready got %b exp 1", ifa.insn_ready); end
        @(negedge clock);
        ifa.insn = ADDI9;
        #1;
        checks++; if (ifa.hazard_waw !== 1'b1) begin errors++; $display("FAIL ld_waw got %b exp 1", ifa.hazard_waw); end
        checks++; if (ifa.hazard_raw !== 1'b0) begin errors++; $display("FAIL ld_raw got %b exp 0", ifa.hazard_raw); end
        checks++; if (ifa.insn_ready !== 1'b0) begin errors++; $display("FAIL ld_ready got %b exp 0", ifa.insn_ready); end
        repeat (4) begin
            @(negedge clock);
            #1;
            checks++; if (ifa.hazard_waw !== 1'b1) begin errors++; $display("FAIL ld_waw_hold got %b exp 1", ifa.hazard_waw); end
        end
        @(negedge clock);
        ifa.wb_valid = 1'b1; ifa.wb_rd = 5'd10;
        @(negedge clock);
        ifa.wb_rd = 5'd9;
        #1;
        checks++; if (ifa.busy !== 32'h0000_0200) begin errors++; $display("FAIL wb_other_ignored got %h exp %h", ifa.busy, 32'h200); end
        checks++; if (ifa.hazard_waw !== 1'b1) begin errors++; $display("FAIL wb_no_bypass got %b exp 1", ifa.hazard_waw); end
        @(negedge clock);
        ifa.wb_valid = 1'b0;
        #1;
        checks++; if (ifa.hazard_waw !== 1'b0) begin errors++; $display("FAIL wb_waw_clear got %b exp 0", ifa.hazard_waw); end
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL wb_ready got %b exp 1", ifa.insn_ready); end
        checks++; if (ifa.busy !== 32'h0) begin errors++; $display("FAIL wb_busy_clear got %h exp 0", ifa.busy); end
        @(negedge clock);
        ifa.insn_valid = 1'b0;
        #1;
        checks++; if (ifa.busy !== 32'h0000_0200) begin errors++; $display("FAIL addi9_issued got %h exp %h", ifa.busy, 32'h200); end
        @(negedge clock);
    endtask

    task automatic test_flush();
        @(negedge clock);
        ifa.insn_valid = 1'b1; ifa.insn = LW9;
        @(negedge clock);
        ifa.insn = MUL7;
        #1;
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL fl_mul_ready got %b exp 1", ifa.insn_ready); end
        @(negedge clock);
        ifa.flush = 1'b1; ifa.insn = ADD11;
        #1;
        checks++; if (ifa.busy !== 32'h0000_0280) begin errors++; $display("FAIL fl_pre_busy got %h exp %h", ifa.busy, 32'h280); end
        @(negedge clock);
        ifa.flush = 1'b0; ifa.insn_valid = 1'b0;
        #1;
        checks++; if (ifa.busy !== 32'h0000_0200) begin errors++; $display("FAIL fl_post_busy got %h exp %h", ifa.busy, 32'h200); end
        ifa.wb_valid = 1'b1; ifa.wb_rd = 5'd9;
        @(negedge clock);
        ifa.wb_valid = 1'b0;
        #1;
        checks++; if (ifa.busy !== 32'h0) begin errors++; $display("FAIL fl_wb_clear got %h exp 0", ifa.busy); end
    endtask

    task automatic test_rv32e();
        @(negedge clock);
        ifb.insn_valid = 1'b1; ifb.insn = ADD17;
        #1;
        checks++; if (ifb.illegal !== 1'b1) begin errors++; $display("FAIL e_rd17_illegal got %b exp 1", ifb.illegal); end
        checks++; if (ifb.insn_ready !== 1'b1) begin errors++; $display("FAIL e_rd17_ready got %b exp 1", ifb.insn_ready); end
        @(negedge clock);
        ifb.insn = ADD1_20;
        #1;
        checks++; if (ifb.busy !== 16'h0) begin errors++; $display("FAIL e_rd17_norec got %h exp 0", ifb.busy); end
        checks++; if (ifb.illegal !== 1'b1) begin errors++; $display("FAIL e_rs20_illegal got %b exp 1", ifb.illegal); end
        @(negedge clock);
        ifb.insn = CSRRWI3;
        #1;
        checks++; if (ifb.illegal !== 1'b0) begin errors++; $display("FAIL e_csrrwi_illegal got %b exp 0", ifb.illegal); end
        checks++; if (ifb.insn_ready !== 1'b1) begin errors++; $display("FAIL e_csrrwi_ready got %b exp 1", ifb.insn_ready); end
        checks++; if (ifb.busy !== 16'h0) begin errors++; $display("FAIL e_rs20_norec got %h exp 0", ifb.busy); end
        @(negedge clock);
        ifb.insn_valid = 1'b0;
        #1;
        checks++; if (ifb.busy !== 16'h0008) begin errors++; $display("FAIL e_csrrwi_rd got %h exp %h", ifb.busy, 16'h8); end
        @(negedge clock);
    endtask

    task automatic test_x0();
        for (int r = 1; r < 32; r++) begin
            @(negedge clock);
            ifa.insn_valid = 1'b1;
            ifa.insn = {12'h000, 5'd0, 3'd2, 5'(r), 7'h03};
        end
        @(negedge clock);
        ifa.insn = ADDI0;
        #1;
        checks++; if (ifa.busy !== 32'hFFFF_FFFE) begin errors++; $display("FAIL x0_all_busy got %h exp %h", ifa.busy, 32'hFFFFFFFE); end
        checks++; if (ifa.hazard_raw !== 1'b0) begin errors++; $display("FAIL x0_addi_raw got %b exp 0", ifa.hazard_raw); end
        checks++; if (ifa.hazard_waw !== 1'b0) begin errors++; $display("FAIL x0_addi_waw got %b exp 0", ifa.hazard_waw); end
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL x0_addi_ready got %b exp 1", ifa.insn_ready); end
        @(negedge clock);
        ifa.insn = BEQ0;
        #1;
        checks++; if (ifa.busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy0 got %b exp 0", ifa.busy[0]); end
        checks++; if (ifa.insn_ready !== 1'b1) begin errors++; $display("FAIL x0_beq_ready got %b exp 1", ifa.insn_ready); end
        @(negedge clock);
        ifa.insn = ADD6_5;
        #1;
        checks++; if (ifa.hazard_raw !== 1'b1) begin errors++; $display("FAIL x0_ctrl_raw got %b exp 1", ifa.hazard_raw); end
        checks++; if (ifa.insn_ready !== 1'b0) begin errors++; $display("FAIL x0_ctrl_ready got %b exp 0", ifa.insn_ready); end
        @(negedge clock);
        ifa.insn_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_raw();
        test_mul_latency();
        test_load_wb();
        test_flush();
        test_rv32e();
        test_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
